// File: rtl/mycpu_mem_io_pkg.sv
// Shared definitions for the mycpu memory/IO responder.
// Holds the IO register map, the status-word bit layout and a helper that
// assembles the status word from its fields.
package mycpu_mem_io_pkg;

  // IO register addresses, decoded from a_in[2:0] when iom_in=1
  localparam logic [2:0] IO_DATA  = 3'd0;
  localparam logic [2:0] IO_STAT  = 3'd1;
  localparam logic [2:0] IO_GPO   = 3'd2;
  localparam logic [2:0] IO_GPI   = 3'd3;
  localparam logic [2:0] IO_RXPOP = 3'd4;

  // Status word bit positions
  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_FULL    = 2;
  localparam int unsigned ST_RX_EMPTY   = 3;
  localparam int unsigned ST_TX_OVF     = 4;
  localparam int unsigned ST_RX_UNF     = 5;
  localparam int unsigned ST_TX_CNT_LSB = 8;
  localparam int unsigned ST_RX_CNT_LSB = 12;

  function automatic logic [15:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_unf,
    input logic [3:0] tx_count,
    input logic [3:0] rx_count
  );
    logic [15:0] s;
    s = '0;
    s[ST_TX_FULL]                    = tx_full;
    s[ST_TX_EMPTY]                   = tx_empty;
    s[ST_RX_FULL]                    = rx_full;
    s[ST_RX_EMPTY]                   = rx_empty;
    s[ST_TX_OVF]                     = tx_ovf;
    s[ST_RX_UNF]                     = rx_unf;
    s[ST_TX_CNT_LSB +: 4]            = tx_count;
    s[ST_RX_CNT_LSB +: 4]            = rx_count;
    return s;
  endfunction

endpackage

// File: rtl/mycpu_mem_io_sync_fifo.sv
// sync_fifo: single-clock FIFO used for the TX and RX streams.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     write request and data; dropped when full unless a pop
//                   is accepted in the same cycle
//   pop             read request; ignored when empty
//   rdata           head entry, 0 when empty
//   full, empty     occupancy flags
//   count           occupancy 0..DEPTH, zero-extended to 4 bits
//   push_drop       a push was dropped this cycle
//   pop_drop        a pop was ignored this cycle
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [3:0]       count,
  output logic             push_drop,
  output logic             pop_drop
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [3:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == 4'(DEPTH));
  assign empty = (cnt == 4'd0);
  assign count = cnt;
  assign rdata = empty ? '0 : store[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign push_drop = push & ~do_push;
  assign pop_drop  = pop & empty;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mycpu_mem_io.sv
// mycpu_mem_io: responder side of the mycpu bus.
// iom_in=0 addresses a word RAM (combinational read, write at clock edge);
// iom_in=1 addresses the IO block: TX/RX stream FIFOs, GPIO output register,
// synchronised GPIO input and sticky status flags.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   a_in, d_in, wen_in, iom_in   CPU address, write data, write enable, space
//   d_out                        RAM read data (always driven from a_in)
//   io_out                       IO read data, 0 when iom_in=0
//   tx_data_out, tx_valid_out, tx_ready_in   outbound stream
//   rx_data_in, rx_valid_in, rx_ready_out    inbound stream
//   gpio_out, gpio_in            GPIO output register, asynchronous inputs
module mycpu_mem_io
  import mycpu_mem_io_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_in,
  input  logic [15:0] d_in,
  input  logic        wen_in,
  input  logic        iom_in,
  output logic [15:0] d_out,
  output logic [15:0] io_out,
  output logic [15:0] tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [15:0] rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic [15:0] gpio_out,
  input  logic [15:0] gpio_in
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  // ---------------- RAM ----------------
  logic [15:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wen_in && !iom_in) mem[a_in[AW-1:0]] <= d_in;
  end

  assign d_out = mem[a_in[AW-1:0]];

  // ---------------- IO decode ----------------
  logic [2:0] io_addr;
  logic       io_wr;

  assign io_addr = a_in[2:0];
  assign io_wr   = wen_in & iom_in;

  // ---------------- FIFOs ----------------
  logic        tx_push, tx_full, tx_empty, tx_push_drop, tx_pop_drop;
  logic [3:0]  tx_count;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_push_drop, rx_pop_drop;
  logic [3:0]  rx_count;
  logic [15:0] rx_head;

  assign tx_push = io_wr & (io_addr == IO_DATA);
  assign rx_pop  = io_wr & (io_addr == IO_RXPOP);
  // Producer handshake is gated by ready, so a full RX never takes a push
  // even when the CPU pops in the same cycle.
  assign rx_push = rx_valid_in & rx_ready_out;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .pop       (tx_ready_in),
    .wdata     (d_in),
    .rdata     (tx_data_out),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .push_drop (tx_push_drop),
    .pop_drop  (tx_pop_drop)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .pop       (rx_pop),
    .wdata     (rx_data_in),
    .rdata     (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .push_drop (rx_push_drop),
    .pop_drop  (rx_pop_drop)
  );

  assign tx_valid_out = ~tx_empty;
  assign rx_ready_out = ~rx_full;

  // ---------------- Flags, GPIO ----------------
  logic        tx_ovf, rx_unf;
  logic        stat_wr;
  logic [15:0] gpi_meta, gpi_sync;

  assign stat_wr = io_wr & (io_addr == IO_STAT);

  // New events take priority over a same-cycle W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
      gpio_out <= '0;
      gpi_meta <= '0;
      gpi_sync <= '0;
    end else begin
      if (tx_push_drop)                   tx_ovf <= 1'b1;
      else if (stat_wr && d_in[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (rx_pop_drop)                    rx_unf <= 1'b1;
      else if (stat_wr && d_in[ST_RX_UNF]) rx_unf <= 1'b0;
      if (io_wr && io_addr == IO_GPO) gpio_out <= d_in;
      gpi_meta <= gpio_in;
      gpi_sync <= gpi_meta;
    end
  end

  // ---------------- IO read mux ----------------
  always_comb begin
    io_out = '0;
    if (iom_in) begin
      case (io_addr)
        IO_DATA: io_out = rx_head;
        IO_STAT: io_out = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                      tx_ovf, rx_unf, tx_count, rx_count);
        IO_GPO:  io_out = gpio_out;
        IO_GPI:  io_out = gpi_sync;
        default: io_out = '0;
      endcase
    end
  end

  // Upper address bits alias in RAM and are ignored in IO space
  logic unused_bits;
  assign unused_bits = ^{a_in, tx_pop_drop, rx_push_drop};

endmodule

// File: tb/tb_mycpu_mem_io.sv
module tb_mycpu_mem_io;

  localparam int unsigned MW = 1024;
  localparam int unsigned FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] d_in = '0;
  logic        wen_in = 1'b0;
  logic        iom_in = 1'b0;
  logic [15:0] d_out;
  logic [15:0] io_out;
  logic [15:0] tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in = 1'b0;
  logic [15:0] rx_data_in = '0;
  logic        rx_valid_in = 1'b0;
  logic        rx_ready_out;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in = '0;

  int n_vec = 0;
  int n_err = 0;

  mycpu_mem_io #(.MEM_WORDS(MW), .FIFO_DEPTH(FD), .INIT_FILE("")) dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .d_in         (d_in),
    .wen_in       (wen_in),
    .iom_in       (iom_in),
    .d_out        (d_out),
    .io_out       (io_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .tx_ready_in  (tx_ready_in),
    .rx_data_in   (rx_data_in),
    .rx_valid_in  (rx_valid_in),
    .rx_ready_out (rx_ready_out),
    .gpio_out     (gpio_out),
    .gpio_in      (gpio_in)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] gpi_h[$];
  logic [15:0] mem_m[int];
  bit          ovf_m, unf_m;
  logic [15:0] gpo_m;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    gpi_h = '{16'h0, 16'h0};
    ovf_m = 0;
    unf_m = 0;
    gpo_m = '0;
  endtask

  function automatic logic [15:0] exp_status();
    int s;
    s = 0;
    if (tx_q.size() == FD) s += 1;
    if (tx_q.size() == 0)  s += 2;
    if (rx_q.size() == FD) s += 4;
    if (rx_q.size() == 0)  s += 8;
    if (ovf_m) s += 16;
    if (unf_m) s += 32;
    s += tx_q.size() * 256;
    s += rx_q.size() * 4096;
    return 16'(s);
  endfunction

  function automatic logic [15:0] exp_io();
    int ad;
    ad = a_in % 8;
    if (!iom_in) return 16'h0;
    case (ad)
      0: return (rx_q.size() != 0) ? rx_q[0] : 16'h0;
      1: return exp_status();
      2: return gpo_m;
      3: return gpi_h[0];
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_update();
    int  idx, ad;
    bit  io_wr, tx_pop, tx_was_full, ovf_set, unf_set, rx_can;
    idx   = a_in % MW;
    ad    = a_in % 8;
    io_wr = wen_in && iom_in;
    ovf_set = 0;
    unf_set = 0;
    if (wen_in && !iom_in) mem_m[idx] = d_in;
    // TX stream
    tx_was_full = (tx_q.size() == FD);
    tx_pop = tx_ready_in && (tx_q.size() != 0);
    if (tx_pop) void'(tx_q.pop_front());
    if (io_wr && ad == 0) begin
      if (tx_was_full && !tx_pop) ovf_set = 1;
      else tx_q.push_back(d_in);
    end
    // RX stream
    rx_can = rx_valid_in && (rx_q.size() < FD);
    if (io_wr && ad == 4) begin
      if (rx_q.size() == 0) unf_set = 1;
      else void'(rx_q.pop_front());
    end
    if (rx_can) rx_q.push_back(rx_data_in);
    // flags
    if (io_wr && ad == 1 && d_in[4]) ovf_m = 0;
    if (io_wr && ad == 1 && d_in[5]) unf_m = 0;
    if (ovf_set) ovf_m = 1;
    if (unf_set) unf_m = 1;
    if (io_wr && ad == 2) gpo_m = d_in;
    gpi_h.push_back(gpio_in);
    void'(gpi_h.pop_front());
  endtask

  // Compare all outputs against the model after inputs have settled
  task automatic settle();
    int idx;
    #1;
    idx = a_in % MW;
    check("io_out", io_out, exp_io());
    check("tx_valid", {15'b0, tx_valid_out}, {15'b0, tx_q.size() != 0});
    check("tx_data", tx_data_out, (tx_q.size() != 0) ? tx_q[0] : 16'h0);
    check("rx_ready", {15'b0, rx_ready_out}, {15'b0, rx_q.size() < FD});
    check("gpio_out", gpio_out, gpo_m);
    if (mem_m.exists(idx)) check("d_out", d_out, mem_m[idx]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic io(input logic [15:0] a, input logic [15:0] d, input logic w);
    iom_in = 1'b1;
    a_in = a;
    d_in = d;
    wen_in = w;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("rst_status", io_out, 16'h000A);
    check("rst_txv", {15'b0, tx_valid_out}, 16'h0);
    check("rst_rxr", {15'b0, rx_ready_out}, 16'h1);
    check("rst_gpo", gpio_out, 16'h0);

    // RAM write, read and aliasing
    iom_in = 1'b0; wen_in = 1'b1; a_in = 16'h0010; d_in = 16'hBEEF;
    settle(); step();
    wen_in = 1'b0;
    settle();
    check("ram_rd", d_out, 16'hBEEF);
    check("ram_io0", io_out, 16'h0);
    a_in = 16'h0410;
    settle();
    check("ram_alias", d_out, 16'hBEEF);

    // TX fill past full
    for (int k = 1; k <= 5; k++) begin
      io(16'h0000, 16'(k), 1'b1);
      settle(); step();
    end
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("tx_full_stat", io_out, 16'h0419);
    tx_ready_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      check("tx_drain", tx_data_out, 16'(k));
      step();
    end
    settle();
    check("tx_empty_stat", io_out, 16'h001A);
    tx_ready_in = 1'b0;
    io(16'h0001, 16'h0010, 1'b1);
    settle(); step();
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("ovf_clr", io_out, 16'h000A);

    // RX push, read, pop, underflow, W1C
    iom_in = 1'b1; wen_in = 1'b0;
    rx_valid_in = 1'b1; rx_data_in = 16'hA5A5;
    settle(); step();
    rx_data_in = 16'h5A5A;
    settle(); step();
    rx_valid_in = 1'b0;
    io(16'h0000, 16'h0, 1'b0);
    settle();
    check("rx_head0", io_out, 16'hA5A5);
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("rx_cnt2", io_out, 16'h2002);
    io(16'h0004, 16'h0, 1'b1);
    settle(); step();
    io(16'h0000, 16'h0, 1'b0);
    settle();
    check("rx_head1", io_out, 16'h5A5A);
    io(16'h0004, 16'h0, 1'b1);
    settle(); step();
    settle(); step();
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("rx_unf", io_out, 16'h002A);
    io(16'h0001, 16'h0020, 1'b1);
    settle(); step();
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("unf_clr", io_out, 16'h000A);

    // Full boundary: push and pop in the same cycle
    for (int k = 0; k < 4; k++) begin
      io(16'h0000, 16'h0011 + 16'(k), 1'b1);
      settle(); step();
    end
    io(16'h0000, 16'h0015, 1'b1);
    tx_ready_in = 1'b1;
    settle(); step();
    tx_ready_in = 1'b0;
    io(16'h0001, 16'h0, 1'b0);
    settle();
    check("full_pp_stat", io_out, 16'h0409);
    tx_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("full_pp_order", tx_data_out, 16'h0012 + 16'(k));
      step();
    end
    tx_ready_in = 1'b0;

    // GPIO input synchroniser latency and output register
    gpio_in = 16'h00FF;
    repeat (3) begin settle(); step(); end
    gpio_in = 16'h1234;
    io(16'h0003, 16'h0, 1'b0);
    settle();
    check("gpi_0edge", io_out, 16'h00FF);
    step(); settle();
    check("gpi_1edge", io_out, 16'h00FF);
    step(); settle();
    check("gpi_2edge", io_out, 16'h1234);
    io(16'h0002, 16'hCAFE, 1'b1);
    settle(); step();
    wen_in = 1'b0;
    settle();
    check("gpo_wr", gpio_out, 16'hCAFE);

    // Reset asserted mid-drain
    for (int k = 0; k < 3; k++) begin
      io(16'h0000, 16'h0021 + 16'(k), 1'b1);
      settle(); step();
    end
    io(16'h0001, 16'h0, 1'b0);
    tx_ready_in = 1'b1;
    settle(); step();
    #2 rst = 1'b1;
    model_reset();
    settle();
    check("mrst_txv", {15'b0, tx_valid_out}, 16'h0);
    check("mrst_rxr", {15'b0, rx_ready_out}, 16'h1);
    check("mrst_gpo", gpio_out, 16'h0);
    check("mrst_stat", io_out, 16'h000A);
    step();
    rst = 1'b0;
    tx_ready_in = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      a_in        = {6'($urandom), 7'b0, 3'($urandom_range(0, 7))};
      iom_in      = 1'($urandom_range(0, 1));
      wen_in      = ($urandom_range(0, 2) == 0);
      d_in        = 16'($urandom);
      tx_ready_in = ($urandom_range(0, 3) == 0);
      rx_valid_in = 1'($urandom_range(0, 1));
      rx_data_in  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
      settle();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
